// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM state and owner encodings plus default bus widths for the memory port arbiter
package mem_port_arbiter_pkg;
  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_ISSUE = 2'd1, ARB_WAIT = 2'd2} arb_state_e;
  typedef enum logic {ARB_OWN_IF = 1'b0, ARB_OWN_DM = 1'b1} arb_owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and bus handshake bundle; slave is the arbiter, master is its environment
interface mem_port_arbiter_if import mem_port_arbiter_pkg::*; #(parameter int AW = ARB_AW, parameter int DW = ARB_DW);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_addr_ok;
  logic          if_data_ok;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_wr;
  logic [DW/8-1:0] dm_wstrb;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_addr_ok;
  logic          dm_data_ok;
  logic [DW-1:0] dm_rdata;
  logic          bus_req;
  logic          bus_wr;
  logic [DW/8-1:0] bus_wstrb;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;
  logic          stallreq_if;
  logic          stallreq_mem;
  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_wstrb, dm_addr, dm_wdata, bus_addr_ok, bus_data_ok, bus_rdata,
    output if_addr_ok, if_data_ok, if_rdata, dm_addr_ok, dm_data_ok, dm_rdata,
           bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, stallreq_if, stallreq_mem
  );
  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_wstrb, dm_addr, dm_wdata, bus_addr_ok, bus_data_ok, bus_rdata,
    input  if_addr_ok, if_data_ok, if_rdata, dm_addr_ok, dm_data_ok, dm_rdata,
           bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/mem_port_arbiter_arb_grant.sv
// arb_grant: one-hot grant {dm, if}; dm wins a tie unless dm was the last one served
module arb_grant (
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       last_served,
  output logic [1:0] gnt
);
  logic g_dm;
  assign g_dm = dm_req & (~if_req | ~last_served);
  assign gnt = {g_dm, if_req & ~g_dm};
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access; ARB_ROUND_ROBIN_EN enables tie alternation
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(parameter int AW = ARB_AW, parameter int DW = ARB_DW) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave p
);
  arb_state_e state, state_n;
  arb_owner_e owner;
  logic            wr;
  logic [DW/8-1:0] wstrb;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [1:0]      gnt;
  logic            last;
  logic            grant, resp;
  assign grant = ~rst & (state == ARB_IDLE) & (|gnt);
  assign resp = ~rst & (state == ARB_WAIT) & p.bus_data_ok;
`ifdef ARB_ROUND_ROBIN_EN
  // remember who was granted last so the next tie goes to the other side
  always_ff @(posedge clk)
    if (rst) last <= ARB_OWN_IF;
    else if (grant) last <= gnt[1];
`else
  assign last = ARB_OWN_IF;
`endif
  arb_grant u_grant (.if_req(p.if_req), .dm_req(p.dm_req), .last_served(last), .gnt(gnt));
  // state register
  always_ff @(posedge clk) state <= rst ? ARB_IDLE : state_n;
  // next state: a response seen in ISSUE is ignored, so a simultaneous accept and response is just an accept
  always_comb begin
    state_n = state;
    case (state)
      ARB_IDLE:  state_n = grant ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE: state_n = p.bus_addr_ok ? ARB_WAIT : ARB_ISSUE;
      ARB_WAIT:  state_n = p.bus_data_ok ? ARB_IDLE : ARB_WAIT;
      default:   state_n = ARB_IDLE;
    endcase
  end
  // capture the granted request; a fetch is always a full read
  always_ff @(posedge clk)
    if (rst) begin
      owner <= ARB_OWN_IF;
      wr <= 1'b0;
      wstrb <= '0;
      addr <= '0;
      wdata <= '0;
    end else if (grant) begin
      owner <= gnt[1] ? ARB_OWN_DM : ARB_OWN_IF;
      wr <= gnt[1] & p.dm_wr;
      wstrb <= gnt[1] ? p.dm_wstrb : '0;
      addr <= gnt[1] ? p.dm_addr : p.if_addr;
      wdata <= gnt[1] ? p.dm_wdata : '0;
    end
  assign p.if_addr_ok = grant & gnt[0];
  assign p.dm_addr_ok = grant & gnt[1];
  assign p.if_data_ok = resp & (owner == ARB_OWN_IF);
  assign p.dm_data_ok = resp & (owner == ARB_OWN_DM);
  assign p.if_rdata = p.if_data_ok ? p.bus_rdata : '0;
  assign p.dm_rdata = p.dm_data_ok ? p.bus_rdata : '0;
  assign p.bus_req = ~rst & (state == ARB_ISSUE);
  assign p.bus_wr = wr;
  assign p.bus_wstrb = wstrb;
  assign p.bus_addr = addr;
  assign p.bus_wdata = wdata;
  assign p.stallreq_if = ~rst & (p.if_req & ~p.if_addr_ok | (owner == ARB_OWN_IF) & (state != ARB_IDLE) & ~p.if_data_ok);
  assign p.stallreq_mem = ~rst & (p.dm_req & ~p.dm_addr_ok | (owner == ARB_OWN_DM) & (state != ARB_IDLE) & ~p.dm_data_ok);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios then random traffic, checked against a transaction-level model
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n_idok = 0;
  int n_ddok = 0;
  int n0_i, n0_d;
  bit m_busy, m_acc, m_own, m_last, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0] m_wstrb;
  mem_port_arbiter_if bus_if ();
  mem_port_arbiter dut (.clk(clk), .rst(rst), .p(bus_if));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit tie_dm, egi, egd, edi, edd, ebr, esi, esm;
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    tie_dm = (m_last == 1'b0);
`else
    tie_dm = 1'b1;
`endif
    egd = !rst && !m_busy && bus_if.dm_req && (!bus_if.if_req || tie_dm);
    egi = !rst && !m_busy && bus_if.if_req && !egd;
    ebr = !rst && m_busy && !m_acc;
    edd = !rst && m_busy && m_acc && m_own && bus_if.bus_data_ok;
    edi = !rst && m_busy && m_acc && !m_own && bus_if.bus_data_ok;
    esi = !rst && ((bus_if.if_req && !egi) || (m_busy && !m_own && !edi));
    esm = !rst && ((bus_if.dm_req && !egd) || (m_busy && m_own && !edd));
    chk("if_addr_ok", 32'(bus_if.if_addr_ok), 32'(egi));
    chk("dm_addr_ok", 32'(bus_if.dm_addr_ok), 32'(egd));
    chk("if_data_ok", 32'(bus_if.if_data_ok), 32'(edi));
    chk("dm_data_ok", 32'(bus_if.dm_data_ok), 32'(edd));
    chk("bus_req", 32'(bus_if.bus_req), 32'(ebr));
    chk("stallreq_if", 32'(bus_if.stallreq_if), 32'(esi));
    chk("stallreq_mem", 32'(bus_if.stallreq_mem), 32'(esm));
    if (edi) chk("if_rdata", bus_if.if_rdata, bus_if.bus_rdata);
    if (edd) chk("dm_rdata", bus_if.dm_rdata, bus_if.bus_rdata);
    if (rst) begin
      chk("if_rdata_rst", bus_if.if_rdata, 32'h0);
      chk("dm_rdata_rst", bus_if.dm_rdata, 32'h0);
    end
    if (ebr) begin
      chk("bus_addr", bus_if.bus_addr, m_addr);
      chk("bus_wr", 32'(bus_if.bus_wr), 32'(m_wr));
      if (m_wr) begin
        chk("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(m_wstrb));
        chk("bus_wdata", bus_if.bus_wdata, m_wdata);
      end
    end
    n_idok += int'(bus_if.if_data_ok);
    n_ddok += int'(bus_if.dm_data_ok);
    @(posedge clk);
    if (rst) begin
      m_busy = 0;
      m_acc = 0;
      m_last = 0;
    end else if (egi || egd) begin
      m_busy = 1;
      m_acc = 0;
      m_own = egd;
      m_last = egd;
      m_addr = egd ? bus_if.dm_addr : bus_if.if_addr;
      m_wr = egd && bus_if.dm_wr;
      m_wstrb = bus_if.dm_wstrb;
      m_wdata = bus_if.dm_wdata;
    end else if (m_busy && !m_acc && bus_if.bus_addr_ok) m_acc = 1;
    else if (m_busy && m_acc && bus_if.bus_data_ok) m_busy = 0;
    #1;
    if (egi) bus_if.if_req = 1'b0;
    if (egd) bus_if.dm_req = 1'b0;
  endtask

  task automatic both_load();
    bus_if.if_req = 1'b1;
    bus_if.if_addr = 32'hBFC00040;
    bus_if.dm_req = 1'b1;
    bus_if.dm_wr = 1'b0;
    bus_if.dm_addr = 32'h80000010;
    bus_if.bus_addr_ok = 1'b1;
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata = 32'h12345678;
    repeat (8) cyc();
  endtask

  initial begin
    bus_if.if_req = 0; bus_if.if_addr = 0;
    bus_if.dm_req = 0; bus_if.dm_wr = 0; bus_if.dm_wstrb = 0; bus_if.dm_addr = 0; bus_if.dm_wdata = 0;
    bus_if.bus_addr_ok = 0; bus_if.bus_data_ok = 0; bus_if.bus_rdata = 0;
    m_busy = 0; m_acc = 0; m_own = 0; m_last = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
    @(posedge clk); #1;
    repeat (2) cyc();
    rst = 1'b0;
    // lone zero-wait fetch; the request drops right after its accept
    n0_i = n_idok;
    bus_if.if_req = 1'b1;
    bus_if.if_addr = 32'hBFC00000;
    bus_if.bus_addr_ok = 1'b1;
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata = 32'h3C010001;
    repeat (4) cyc();
    chk("lone_fetch_count", n_idok - n0_i, 1);
    // simultaneous requests, then four more ties
    both_load();
    repeat (4) both_load();
    // delayed-accept store
    n0_i = n_idok;
    n0_d = n_ddok;
    bus_if.dm_req = 1'b1;
    bus_if.dm_wr = 1'b1;
    bus_if.dm_wstrb = 4'b0011;
    bus_if.dm_wdata = 32'hDEADBEEF;
    bus_if.dm_addr = 32'h80000020;
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b0;
    repeat (4) cyc();
    bus_if.bus_addr_ok = 1'b1;
    cyc();
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    cyc();
    bus_if.bus_data_ok = 1'b0;
    repeat (2) cyc();
    chk("store_dm_data_ok", n_ddok - n0_d, 1);
    chk("store_if_data_ok", n_idok - n0_i, 0);
    // reset while waiting, then a stray response
    n0_i = n_idok;
    bus_if.if_req = 1'b1;
    bus_if.if_addr = 32'hBFC00100;
    bus_if.bus_addr_ok = 1'b1;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    repeat (2) cyc();
    chk("abort_no_data_ok", n_idok - n0_i, 0);
    bus_if.if_req = 1'b1;
    repeat (4) cyc();
    chk("after_reset_fetch", n_idok - n0_i, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!bus_if.if_req && $urandom_range(2) == 0) begin
        bus_if.if_req = 1'b1;
        bus_if.if_addr = $urandom;
      end
      if (!bus_if.dm_req && $urandom_range(2) == 0) begin
        bus_if.dm_req = 1'b1;
        bus_if.dm_wr = 1'($urandom_range(1));
        bus_if.dm_wstrb = 4'($urandom);
        bus_if.dm_addr = $urandom;
        bus_if.dm_wdata = $urandom;
      end
      bus_if.bus_addr_ok = 1'($urandom_range(1));
      bus_if.bus_data_ok = 1'($urandom_range(1));
      bus_if.bus_rdata = $urandom;
      rst = ($urandom_range(199) == 0);
      cyc();
    end
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
